// File: rtl/fp_accum.sv
// fp_accum: bf16 group accumulator fed by the PE multiplier.
// Sums a stream of bf16 products, one group per in_last, into a bf16
// running sum. Each beat passes through align, add and normalize cycles.
// The result is held with a beat count and sticky flags until the
// consumer accepts it.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-low reset
//   in_valid/in_ready   product beat handshake
//   in_data             bf16 product {sign, exp[7:0], mant[6:0]}
//   in_last             final beat of the group
//   in_overflow/in_inexact   multiplier flags for the beat
//   out_valid/out_ready result handshake
//   out_sum             bf16 group sum
//   out_count           beats in the group (saturating at 2^CNT_W-1)
//   out_overflow/out_inexact/out_underflow   sticky group flags
//
// Build option: define FP_ACCUM_RNE_EN to round to nearest-even in the
// normalize step. When it is undefined the mantissa is truncated.
//
// state   | meaning
// S_WAIT  | ready for a product beat
// S_ALIGN | order operands by magnitude, align the smaller mantissa
// S_ADD   | add or subtract the aligned mantissas
// S_NORM  | normalize, round/truncate, write acc
// S_OUT   | hold the group result until out_ready

module fp_accum #(
   parameter int CNT_W = 8
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_data,
   input  logic             in_last,
   input  logic             in_overflow,
   input  logic             in_inexact,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [15:0]      out_sum,
   output logic [CNT_W-1:0] out_count,
   output logic             out_overflow,
   output logic             out_inexact,
   output logic             out_underflow
);

   typedef enum logic [2:0] {S_WAIT, S_ALIGN, S_ADD, S_NORM, S_OUT} state_t;

   state_t            state, state_nx;
   logic [15:0]       acc, op;
   logic              op_last;
   logic [CNT_W-1:0]  cnt;
   logic              s_ovf, s_inx, s_unf;
   logic              valid_q;

   // align stage registers
   logic              r_byp;
   logic [15:0]       r_byp_res;
   logic              r_sign, r_sub;
   logic [7:0]        r_exp;
   logic [10:0]       r_a, r_b;
   // add stage register
   logic [11:0]       r_sum;

   // align combinational
   logic              c_byp, c_ovf, c_lost, c_acc_big;
   logic [15:0]       c_byp_res, c_big, c_small;
   logic [7:0]        c_diff;
   logic [3:0]        c_shamt;
   logic [21:0]       c_ext;
   logic [10:0]       c_a, c_b;

   // add / normalize combinational
   logic [11:0]       add_sum;
   logic [3:0]        lz;
   logic [10:0]       n_man;
   logic [6:0]        n_m7;
   logic signed [9:0] n_exp;
   logic [15:0]       n_res;
   logic              n_ovf, n_unf, n_inx;

   function automatic logic [3:0] lzc11(input logic [10:0] v);
      logic [3:0] n;
      logic       done;
      n    = 4'd0;
      done = 1'b0;
      for (int i = 10; i >= 0; i--) begin
         if (!done) begin
            if (v[i]) done = 1'b1;
            else      n = n + 4'd1;
         end
      end
      return n;
   endfunction

   assign in_ready      = (state == S_WAIT);
   assign out_valid     = valid_q;
   assign out_sum       = acc;
   assign out_count     = cnt;
   assign out_overflow  = s_ovf;
   assign out_inexact   = s_inx;
   assign out_underflow = s_unf;

   always_comb begin
      state_nx = state;
      case (state)
         S_WAIT:  if (in_valid) state_nx = S_ALIGN;
         S_ALIGN: state_nx = S_ADD;
         S_ADD:   state_nx = S_NORM;
         S_NORM:  state_nx = op_last ? S_OUT : S_WAIT;
         S_OUT:   if (valid_q && out_ready) state_nx = S_WAIT;
         default: state_nx = S_WAIT;
      endcase
   end

   // Special operands (infinity, flushed zero, empty acc) skip the datapath
   // and carry their result through to S_NORM so every beat takes 4 cycles.
   always_comb begin
      c_byp     = 1'b0;
      c_byp_res = acc;
      c_ovf     = 1'b0;
      c_lost    = 1'b0;
      c_acc_big = 1'b0;
      c_big     = acc;
      c_small   = op;
      c_diff    = 8'd0;
      c_shamt   = 4'd0;
      c_ext     = 22'd0;
      c_a       = 11'd0;
      c_b       = 11'd0;
      if (acc[14:7] == 8'hFF) begin
         c_byp = 1'b1;
      end else if (op[14:7] == 8'hFF) begin
         c_byp     = 1'b1;
         c_byp_res = {op[15], 8'hFF, 7'h00};
         c_ovf     = 1'b1;
      end else if (op[14:7] == 8'h00) begin
         c_byp = 1'b1;
      end else if (acc[14:7] == 8'h00) begin
         c_byp     = 1'b1;
         c_byp_res = op;
      end else begin
         c_acc_big = (acc[14:7] > op[14:7]) ||
                     ((acc[14:7] == op[14:7]) && (acc[6:0] >= op[6:0]));
         c_big     = c_acc_big ? acc : op;
         c_small   = c_acc_big ? op : acc;
         c_diff    = c_big[14:7] - c_small[14:7];
         c_shamt   = (c_diff > 8'd11) ? 4'd11 : c_diff[3:0];
         c_ext     = {1'b1, c_small[6:0], 3'b000, 11'd0} >> c_shamt;
         c_a       = {1'b1, c_big[6:0], 3'b000};
         c_b       = c_ext[21:11];
         c_lost    = |c_ext[10:0];
      end
   end

   assign add_sum = r_sub ? ({1'b0, r_a} - {1'b0, r_b})
                          : ({1'b0, r_a} + {1'b0, r_b});

   assign lz = lzc11(r_sum[10:0]);

   always_comb begin
      n_res = 16'h0000;
      n_ovf = 1'b0;
      n_unf = 1'b0;
      n_inx = 1'b0;
      n_man = 11'd0;
      n_m7  = 7'd0;
      n_exp = 10'sd0;
      if (r_sum != 12'd0) begin
         if (r_sum[11]) begin
            n_man = r_sum[11:1];
            n_inx = r_sum[0];
            n_exp = $signed({2'b00, r_exp}) + 10'sd1;
         end else begin
            n_man = r_sum[10:0] << lz;
            n_exp = $signed({2'b00, r_exp}) - $signed({6'd0, lz});
         end
         if (n_man[2:0] != 3'b000) n_inx = 1'b1;
         n_m7 = n_man[9:3];
`ifdef FP_ACCUM_RNE_EN
         if ((n_man[2:0] > 3'b100) || ((n_man[2:0] == 3'b100) && n_m7[0])) begin
            if (n_m7 == 7'h7F) begin
               n_m7  = 7'h00;
               n_exp = n_exp + 10'sd1;
            end else begin
               n_m7 = n_m7 + 7'd1;
            end
         end
`endif
         if (n_exp >= 10'sd255) begin
            n_res = {r_sign, 8'hFF, 7'h00};
            n_ovf = 1'b1;
         end else if (n_exp <= 10'sd0) begin
            n_res = 16'h0000;
            n_unf = 1'b1;
         end else begin
            n_res = {r_sign, n_exp[7:0], n_m7};
         end
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= S_WAIT;
         acc       <= 16'h0000;
         op        <= 16'h0000;
         op_last   <= 1'b0;
         cnt       <= '0;
         s_ovf     <= 1'b0;
         s_inx     <= 1'b0;
         s_unf     <= 1'b0;
         valid_q   <= 1'b0;
         r_byp     <= 1'b0;
         r_byp_res <= 16'h0000;
         r_sign    <= 1'b0;
         r_sub     <= 1'b0;
         r_exp     <= 8'd0;
         r_a       <= 11'd0;
         r_b       <= 11'd0;
         r_sum     <= 12'd0;
      end else begin
         state <= state_nx;
         case (state)
            S_WAIT: begin
               if (in_valid) begin
                  op      <= in_data;
                  op_last <= in_last;
                  s_ovf   <= s_ovf | in_overflow;
                  s_inx   <= s_inx | in_inexact;
                  if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
               end
            end
            S_ALIGN: begin
               r_byp     <= c_byp;
               r_byp_res <= c_byp_res;
               r_sign    <= c_big[15];
               r_sub     <= c_big[15] ^ c_small[15];
               r_exp     <= c_big[14:7];
               r_a       <= c_a;
               r_b       <= c_b;
               s_ovf     <= s_ovf | c_ovf;
               s_inx     <= s_inx | c_lost;
            end
            S_ADD: begin
               r_sum <= add_sum;
            end
            S_NORM: begin
               if (r_byp) begin
                  acc <= r_byp_res;
               end else begin
                  acc   <= n_res;
                  s_ovf <= s_ovf | n_ovf;
                  s_inx <= s_inx | n_inx;
                  s_unf <= s_unf | n_unf;
               end
            end
            S_OUT: begin
               // out_valid rises one cycle after acc settles
               if (!valid_q) begin
                  valid_q <= 1'b1;
               end else if (out_ready) begin
                  valid_q <= 1'b0;
                  acc     <= 16'h0000;
                  cnt     <= '0;
                  s_ovf   <= 1'b0;
                  s_inx   <= 1'b0;
                  s_unf   <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_accum.sv
module tb_fp_accum;

   logic        clock = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, in_last, in_overflow, in_inexact;
   logic [15:0] in_data;
   logic        out_valid, out_ready;
   logic [15:0] out_sum;
   logic [7:0]  out_count;
   logic        out_overflow, out_inexact, out_underflow;

   int passed = 0;
   int total  = 0;

   fp_accum #(.CNT_W(8)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_last(in_last), .in_overflow(in_overflow), .in_inexact(in_inexact),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_count(out_count), .out_overflow(out_overflow),
      .out_inexact(out_inexact), .out_underflow(out_underflow)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic send(input logic [15:0] d, input logic l, input logic ov, input logic ix);
      int n = 0;
      @(negedge clock);
      in_valid = 1'b1; in_data = d; in_last = l; in_overflow = ov; in_inexact = ix;
      while (!in_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         total++;
         $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
      end
      @(posedge clock);
      #1;
      in_valid = 1'b0; in_last = 1'b0; in_overflow = 1'b0; in_inexact = 1'b0;
   endtask

   // returns edges from the accept edge until out_valid is seen high
   task automatic wait_out(output int edges);
      edges = 0;
      while (!out_valid && edges < 30) begin
         @(posedge clock);
         #1;
         edges++;
      end
      if (!out_valid) begin
         total++;
         $display("FAIL result_timeout: out_valid=%b required 1", out_valid);
      end
   endtask

   task automatic take();
      @(negedge clock);
      out_ready = 1'b1;
      @(posedge clock);
      #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", out_valid); else passed++;
      total++; if (out_sum !== 16'h0000) $display("FAIL rst_sum: got %h want 0000", out_sum); else passed++;
      total++; if (out_count !== 8'd0) $display("FAIL rst_count: got %0d want 0", out_count); else passed++;
      total++; if ({out_overflow, out_inexact, out_underflow} !== 3'b000)
         $display("FAIL rst_flags: got %b want 000", {out_overflow, out_inexact, out_underflow}); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", in_ready); else passed++;
   endtask

   task automatic test_basic_add();
      int e;
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'h4000, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (e !== 4) $display("FAIL basic_latency: got %0d want 4", e); else passed++;
      total++; if (out_sum !== 16'h4040) $display("FAIL basic_sum: got %h want 4040", out_sum); else passed++;
      total++; if (out_count !== 8'd2) $display("FAIL basic_count: got %0d want 2", out_count); else passed++;
      total++; if ({out_overflow, out_inexact, out_underflow} !== 3'b000)
         $display("FAIL basic_flags: got %b want 000", {out_overflow, out_inexact, out_underflow}); else passed++;
      take();
   endtask

   task automatic test_signs();
      int e;
      send(16'hC000, 1'b0, 1'b0, 1'b0);
      send(16'h3F80, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'hBF80) $display("FAIL signs_sum: got %h want bf80", out_sum); else passed++;
      take();
   endtask

   task automatic test_cancel();
      int e;
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'hBF80, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'h0000) $display("FAIL cancel_sum: got %h want 0000", out_sum); else passed++;
      total++; if (out_underflow !== 1'b0) $display("FAIL cancel_unf: got %b want 0", out_underflow); else passed++;
      total++; if (out_inexact !== 1'b0) $display("FAIL cancel_inx: got %b want 0", out_inexact); else passed++;
      take();
   endtask

   task automatic test_overflow();
      int e;
      send(16'h7F00, 1'b0, 1'b0, 1'b0);
      send(16'h7F00, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'h7F80) $display("FAIL ovf_sum: got %h want 7f80", out_sum); else passed++;
      total++; if (out_overflow !== 1'b1) $display("FAIL ovf_flag: got %b want 1", out_overflow); else passed++;
      take();
      send(16'h3F80, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'h3F80) $display("FAIL ovf_next_sum: got %h want 3f80", out_sum); else passed++;
      total++; if (out_overflow !== 1'b0) $display("FAIL ovf_next_flag: got %b want 0", out_overflow); else passed++;
      total++; if (out_count !== 8'd1) $display("FAIL ovf_next_count: got %0d want 1", out_count); else passed++;
      take();
   endtask

   task automatic test_inf_operand();
      int e;
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'hFF80, 1'b0, 1'b0, 1'b0);
      send(16'h4000, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'hFF80) $display("FAIL inf_sum: got %h want ff80", out_sum); else passed++;
      total++; if (out_overflow !== 1'b1) $display("FAIL inf_flag: got %b want 1", out_overflow); else passed++;
      take();
   endtask

   task automatic test_flags_denormal();
      int e;
      send(16'h4000, 1'b0, 1'b1, 1'b0);
      send(16'h0012, 1'b1, 1'b0, 1'b1);
      wait_out(e);
      total++; if (out_sum !== 16'h4000) $display("FAIL denorm_sum: got %h want 4000", out_sum); else passed++;
      total++; if ({out_overflow, out_inexact, out_underflow} !== 3'b110)
         $display("FAIL denorm_flags: got %b want 110", {out_overflow, out_inexact, out_underflow}); else passed++;
      total++; if (out_count !== 8'd2) $display("FAIL denorm_count: got %0d want 2", out_count); else passed++;
      take();
   endtask

   task automatic test_rounding();
      int e;
      logic [15:0] exp_sum;
`ifdef FP_ACCUM_RNE_EN
      exp_sum = 16'h3F81;
`else
      exp_sum = 16'h3F80;
`endif
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'h3BC0, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== exp_sum) $display("FAIL round_sum: got %h want %h", out_sum, exp_sum); else passed++;
      total++; if (out_inexact !== 1'b1) $display("FAIL round_inx: got %b want 1", out_inexact); else passed++;
      take();
   endtask

   task automatic test_backpressure();
      int e;
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'h3F80, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         total++; if (out_valid !== 1'b1) $display("FAIL bp_valid[%0d]: got %b want 1", i, out_valid); else passed++;
         total++; if (out_sum !== 16'h4000) $display("FAIL bp_sum[%0d]: got %h want 4000", i, out_sum); else passed++;
         total++; if (in_ready !== 1'b0) $display("FAIL bp_ready[%0d]: got %b want 0", i, in_ready); else passed++;
      end
      take();
      total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b want 1", in_ready); else passed++;
      send(16'h3F80, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_sum !== 16'h3F80) $display("FAIL bp_next_sum: got %h want 3f80", out_sum); else passed++;
      total++; if (out_count !== 8'd1) $display("FAIL bp_next_count: got %0d want 1", out_count); else passed++;
      take();
   endtask

   task automatic test_reset_mid();
      int e;
      send(16'h3F80, 1'b0, 1'b0, 1'b0);
      send(16'h4000, 1'b1, 1'b0, 1'b0);
      @(posedge clock);
      #1;
      reset = 1'b0;
      @(posedge clock);
      #1;
      total++; if (out_valid !== 1'b0) $display("FAIL midrst_valid: got %b want 0", out_valid); else passed++;
      total++; if (in_ready !== 1'b1) $display("FAIL midrst_ready: got %b want 1", in_ready); else passed++;
      reset = 1'b1;
      send(16'h4000, 1'b1, 1'b0, 1'b0);
      wait_out(e);
      total++; if (e !== 4) $display("FAIL midrst_latency: got %0d want 4", e); else passed++;
      total++; if (out_sum !== 16'h4000) $display("FAIL midrst_sum: got %h want 4000", out_sum); else passed++;
      total++; if (out_count !== 8'd1) $display("FAIL midrst_count: got %0d want 1", out_count); else passed++;
      take();
   endtask

   task automatic test_count_sat();
      int e;
      for (int i = 0; i < 256; i++) send(16'h3F80, (i == 255), 1'b0, 1'b0);
      wait_out(e);
      total++; if (out_count !== 8'd255) $display("FAIL sat_count: got %0d want 255", out_count); else passed++;
      total++; if (out_sum !== 16'h4380) $display("FAIL sat_sum: got %h want 4380", out_sum); else passed++;
      take();
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; in_data = 16'h0000; in_last = 1'b0;
      in_overflow = 1'b0; in_inexact = 1'b0; out_ready = 1'b0;
      test_reset();
      test_basic_add();
      test_signs();
      test_cancel();
      test_overflow();
      test_inf_operand();
      test_flags_denormal();
      test_rounding();
      test_backpressure();
      test_reset_mid();
      test_count_sat();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
